sequence_gen: RTL and testbench
===============================

Name: sequence_gen

Overview:
- Bit-serial pattern transmitter. It is the source side of the serial sequence-detector path: it drives the detector's 1-bit `in` with a programmable bit pattern.
- It captures a pattern, length and repeat count on a start strobe. It then shifts the pattern out MSB-first, one bit per clock, repeating it with a fixed idle gap between repetitions.
- It is used as the stimulus and traffic source for the detector and for system-level loopback.

Parameters:
- PAT_W, 8: width of the pattern register, i.e. the maximum pattern length in bits.
- LEN_W, 4: width of the len input. Must satisfy 2^LEN_W > PAT_W.
- REP_W, 4: width of the reps input.
- GAP_CYCLES, 2: number of idle cycles (out_valid=0) between repetitions. 0 means back-to-back repetitions.

Ports:
- clk, input, 1: single clock. All state changes on its rising edge.
- rst, input, 1: reset. Asynchronous, active-low (0 = reset).
- start, input, 1: request strobe. Sampled only in IDLE.
- pattern, input, PAT_W: bits to send. The active field is pattern[len-1:0].
- len, input, LEN_W: pattern length in bits.
- reps, input, REP_W: number of repetitions.
- out, output, 1: serial data bit, registered.
- out_valid, output, 1: out carries a pattern bit this cycle.
- busy, output, 1: a transfer is in progress and start is ignored.
- done, output, 1: single-cycle pulse when a transfer completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - out=0, out_valid=0, busy=0, done=0.
  - Captured pattern, length, bit counter, repetition counter and gap counter all cleared.
  - Reset asserted mid-transfer aborts the transfer immediately, with no done pulse.
  - The first start is honoured at the first rising edge after rst returns to 1.
- States: IDLE, SEND, GAP. All outputs are registered and change only on clk rising edges, except under reset.
- Operand normalisation at capture:
  - len=0 or len>PAT_W: use PAT_W.
  - reps=0: use 1.
- IDLE, start=1 at edge N:
  - Capture pattern, normalised len L and normalised reps R.
  - Go to SEND with out=pattern[L-1], out_valid=1, busy=1.
  - done falls to 0 at this edge if it was high.
- SEND:
  - Each edge presents the next lower bit. Bit k of the repetition (k = 0..L-1) appears on out with out_valid=1 during the cycle after edge N+k.
  - After the last bit (pattern[0]) is presented, the next edge does one of the following:
    - More repetitions remain and GAP_CYCLES>0: go to GAP with out=0, out_valid=0, busy=1.
    - More repetitions remain and GAP_CYCLES=0: stay in SEND and present pattern[L-1] of the next repetition, so there is no bubble.
    - Final repetition: go to IDLE with out=0, out_valid=0, busy=0, done=1.
- GAP:
  - Exactly GAP_CYCLES cycles with out_valid=0 and out=0.
  - The edge ending the gap re-enters SEND presenting pattern[L-1].
- Transfer length: total out_valid-high cycles = L*R. Cycle count from start edge to the done edge = L*R + (R-1)*GAP_CYCLES.
- done:
  - High for exactly one cycle, the first IDLE cycle after a transfer.
  - start sampled high at the edge ending that cycle is accepted, giving back-to-back transfers with one idle cycle between them.
- start while busy=1: ignored, not queued.
- Changes to pattern, len or reps while busy: no effect on the current transfer.
- Counters:
  - Bit counter is LEN_W wide, counts L-1 down to 0.
  - Repetition counter is REP_W wide, counts R-1 down to 0.
  - Gap counter is sized from GAP_CYCLES, with a minimum of 1 bit.
  - No wrap-around is permitted within a transfer.

Test Plan:
- Single pattern: PAT_W=8, GAP=2; pattern=8'b0000_1011, len=4, reps=1, start pulse -> out 1,0,1,1 on 4 consecutive valid cycles, then done=1 for 1 cycle; busy high exactly 4 cycles.
- Repeat with gap: same pattern, reps=3 -> valid stream 1011 _ _ 1011 _ _ 1011 (_ = out_valid 0); 12 valid cycles; done on the 17th cycle after start.
- Normalisation: len=0, pattern=8'hA5, reps=0 -> 8 bits 1,0,1,0,0,1,0,1, single repetition, done pulse.
- Start while busy: start re-asserted during SEND with a different pattern -> ignored, original stream intact. Start held high through the done cycle -> new transfer starts the next cycle.
- Reset mid-transfer: rst=0 after 2 bits of a len=8 send -> out, out_valid, busy and done go to 0 immediately; no done pulse; a fresh start after release sends from the MSB.
- Loopback: drive the sequence detector's in from out (gated by out_valid), pattern 1011, reps=2, GAP=0 -> detector detected asserts at the positions expected for the 10111011 stream.

Source files
------------

// File: rtl/sequence_gen.sv
// sequence_gen: bit-serial pattern transmitter.
//
// Captures pattern/len/reps on a start strobe while idle. It then shifts
// pattern[L-1:0] out MSB-first, one bit per clock, R times. Repetitions are
// separated by GAP_CYCLES idle cycles. All outputs are registered.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous reset, active low
//   start     - request strobe, sampled only while idle
//   pattern   - bits to send, active field pattern[len-1:0]
//   len       - pattern length (0 or >PAT_W means PAT_W)
//   reps      - repetition count (0 means 1)
//   out       - serial data bit
//   out_valid - out carries a pattern bit this cycle
//   busy      - transfer in progress, start ignored
//   done      - one-cycle pulse in the first idle cycle after a transfer
module sequence_gen #(
  parameter int PAT_W      = 8,
  parameter int LEN_W      = 4,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] PAT_L  = LEN_W'(PAT_W);
  localparam logic [GW-1:0]    GAP_M1 = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;   // captured pattern, MSB-aligned to bit PAT_W-1
  logic [PAT_W-1:0] sh_q,  sh_n;    // bits of the current repetition not yet shown
  logic [LEN_W-1:0] lm1_q, lm1_n;   // L-1, reload value of the bit counter
  logic [LEN_W-1:0] bit_q, bit_n;
  logic [REP_W-1:0] rep_q, rep_n;
  logic [GW-1:0]    gap_q, gap_n;
  logic             out_n, vld_n, busy_n, done_n;

  // Operand normalisation at capture
  logic [LEN_W-1:0] l_norm;
  logic [REP_W-1:0] r_norm;
  logic [PAT_W-1:0] pat_al;

  always_comb begin
    l_norm = (len == '0 || len > PAT_L) ? PAT_L : len;
    r_norm = (reps == '0) ? REP_W'(1) : reps;
    // Left-align the active field so the MSB to send is always bit PAT_W-1.
    pat_al = pattern << (PAT_L - l_norm);
  end

  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    sh_n    = sh_q;
    lm1_n   = lm1_q;
    bit_n   = bit_q;
    rep_n   = rep_q;
    gap_n   = gap_q;
    out_n   = 1'b0;
    vld_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          pat_n   = pat_al;
          sh_n    = pat_al << 1;
          lm1_n   = l_norm - 1'b1;
          bit_n   = l_norm - 1'b1;
          rep_n   = r_norm - 1'b1;
          out_n   = pat_al[PAT_W-1];
          vld_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SEND: begin
        busy_n = 1'b1;
        if (bit_q != '0) begin
          bit_n = bit_q - 1'b1;
          out_n = sh_q[PAT_W-1];
          sh_n  = sh_q << 1;
          vld_n = 1'b1;
        end else if (rep_q != '0) begin
          rep_n = rep_q - 1'b1;
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n   = GAP_M1;
          end else begin
            // No gap: first bit of the next repetition follows with no bubble.
            out_n = pat_q[PAT_W-1];
            sh_n  = pat_q << 1;
            bit_n = lm1_q;
            vld_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_q != '0) begin
          gap_n = gap_q - 1'b1;
        end else begin
          state_n = SEND;
          out_n   = pat_q[PAT_W-1];
          sh_n    = pat_q << 1;
          bit_n   = lm1_q;
          vld_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      lm1_q     <= '0;
      bit_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      pat_q     <= pat_n;
      sh_q      <= sh_n;
      lm1_q     <= lm1_n;
      bit_q     <= bit_n;
      rep_q     <= rep_n;
      gap_q     <= gap_n;
      out       <= out_n;
      out_valid <= vld_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_sequence_gen.sv
// Testbench for sequence_gen: table vectors, hand-written corner sequences,
// randomized transfers against a trace model, and a GAP_CYCLES=0 loopback
// into a 1011 detector model.
module tb_sequence_gen;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst, start, start0;
  logic [7:0] pattern;
  logic [3:0] len, reps;
  logic       out, out_valid, busy, done;
  logic       out0, vld0, busy0, done0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];  // per-cycle {out_valid, out, busy, done}

  always #5 clk = ~clk;

  sequence_gen #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done));

  sequence_gen #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pattern(pattern), .len(len), .reps(reps),
    .out(out0), .out_valid(vld0), .busy(busy0), .done(done0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a transfer at the current negedge and follows it to its done cycle.
  // The expected trace is built from the transfer rules: L bits MSB-first,
  // R times, GAP idle cycles between, then one done cycle.
  // noise: scramble inputs while busy. hold: keep start high throughout and
  // return with it still high, so the caller can chain a transfer.
  task automatic run_xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                          input bit noise, input bit hold,
                          output int nvalid, output int done_at, output logic [7:0] first);
    int  L, R;
    bit  seen;
    L = (l == 0 || l > 8) ? 8 : int'(l);
    R = (r == 0) ? 1 : int'(r);
    exp_q.delete();
    for (int i = 0; i < R; i++) begin
      for (int k = L - 1; k >= 0; k--) exp_q.push_back({1'b1, p[k], 1'b1, 1'b0});
      if (i < R - 1) for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    pattern = p; len = l; reps = r; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    nvalid = 0; done_at = -1; first = '0; seen = 1'b0;
    for (int c = 1; c <= exp_q.size() + 4 && !seen; c++) begin
      if (c <= exp_q.size())
        check($sformatf("trace p=%0h l=%0d r=%0d c%0d", p, l, r, c),
              {out_valid, out, busy, done}, exp_q[c-1]);
      if (out_valid) begin
        nvalid++;
        if (nvalid <= 8) first[8-nvalid] = out;
      end
      if (done) begin
        done_at = c - 1;
        seen    = 1'b1;
      end else begin
        @(negedge clk);
        if (noise) begin
          start = 1'($urandom); pattern = 8'($urandom);
          len = 4'($urandom); reps = 4'($urandom);
        end
      end
    end
    check("done seen", 32'(seen), 32'd1);
    if (!hold) start = 1'b0;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check(name, {out_valid, out, busy, done}, 4'b0000);
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] reps;
    int         nvalid;
    int         done_at;
    logic [7:0] first;  // first 8 valid bits, earliest in bit 7
  } vec_t;

  vec_t vecs[$];

  initial begin
    int         nv, da;
    logic [7:0] fb;
    logic [3:0] sh;
    int         det[$];
    int         cnt;
    bit         fin;

    vecs.push_back('{8'h0B, 4'd4,  4'd1,  4,   4,   8'hB0});
    vecs.push_back('{8'h0B, 4'd4,  4'd3,  12,  16,  8'hBB});
    vecs.push_back('{8'hA5, 4'd0,  4'd0,  8,   8,   8'hA5});
    vecs.push_back('{8'hA5, 4'd9,  4'd2,  16,  18,  8'hA5});
    vecs.push_back('{8'hF1, 4'd1,  4'd0,  1,   1,   8'h80});
    vecs.push_back('{8'h3C, 4'd3,  4'd2,  6,   8,   8'h90});
    vecs.push_back('{8'hC6, 4'd2,  4'd3,  6,   10,  8'hA8});
    vecs.push_back('{8'h81, 4'd8,  4'd4,  32,  38,  8'h81});
    vecs.push_back('{8'h5A, 4'd15, 4'd15, 120, 148, 8'h5A});

    rst = 1'b0; start = 1'b0; start0 = 1'b0;
    pattern = '0; len = '0; reps = '0;
    repeat (2) @(negedge clk);
    check("reset dut", {out_valid, out, busy, done}, 4'b0000);
    check("reset dut0", {vld0, out0, busy0, done0}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    idle_check("idle after reset");

    // Table vectors
    foreach (vecs[i]) begin
      run_xfer(vecs[i].pat, vecs[i].len, vecs[i].reps, 1'b0, 1'b0, nv, da, fb);
      check($sformatf("vec%0d nvalid", i), nv, vecs[i].nvalid);
      check($sformatf("vec%0d done_at", i), da, vecs[i].done_at);
      check($sformatf("vec%0d bits", i), fb, vecs[i].first);
      idle_check($sformatf("vec%0d idle", i));
    end

    // Start and operand changes while busy are ignored
    run_xfer(8'h0B, 4'd4, 4'd3, 1'b1, 1'b0, nv, da, fb);
    check("noise nvalid", nv, 12);
    idle_check("noise idle");

    // Start held through the done cycle chains the next transfer immediately
    run_xfer(8'h0B, 4'd4, 4'd1, 1'b0, 1'b1, nv, da, fb);
    check("hold done_at", da, 4);
    run_xfer(8'hA5, 4'd8, 4'd1, 1'b0, 1'b0, nv, da, fb);
    check("chained bits", fb, 8'hA5);
    idle_check("chained idle");

    // Reset mid-transfer: outputs drop without waiting for a clock edge
    pattern = 8'hA5; len = 4'd8; reps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset busy", {out_valid, out, busy}, 3'b101);
    #1 rst = 1'b0;
    #1 check("reset async", {out_valid, out, busy, done}, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      check("in reset", {out_valid, out, busy, done}, 4'b0000);
    end
    rst = 1'b1;
    run_xfer(8'h3C, 4'd8, 4'd1, 1'b0, 1'b0, nv, da, fb);
    check("post-reset bits", fb, 8'h3C);
    idle_check("post-reset idle");

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      run_xfer(8'($urandom), 4'($urandom), 4'($urandom_range(0, 3)),
               1'($urandom), 1'b0, nv, da, fb);
      idle_check($sformatf("rand%0d idle", t));
    end

    // Loopback: GAP_CYCLES=0 generator feeding a 1011 detector model
    pattern = 8'h0B; len = 4'd4; reps = 4'd2; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    sh = '0; cnt = 0; da = -1; fin = 1'b0;
    for (int c = 1; c <= 16 && !fin; c++) begin
      if (vld0) begin
        sh = {sh[2:0], out0};
        if (cnt >= 3 && sh == 4'b1011) det.push_back(cnt);
        cnt++;
      end
      if (done0) begin
        da  = c - 1;
        fin = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("loop nvalid", cnt, 8);
    check("loop done_at", da, 8);
    check("loop det count", det.size(), 2);
    if (det.size() == 2) begin
      check("loop det0", det[0], 3);
      check("loop det1", det[1], 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
